mem_stage: RTL and testbench

Memory-access stage of the 32-bit pipeline, sitting on the consuming side of the EX/MEM pipeline register. It takes the memory controls and operands the execute stage registers (read/write enables, data address, store data, destination register, write-back controls) and turns them into a request/acknowledge transaction on the data-memory bus. It stalls the upstream pipeline until the access completes, resolves the branch decision, and owns the MEM/WB pipeline register.

---
 rtl/mem_stage.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the 32-bit pipeline. Consumes the EX/MEM register
// outputs, runs a request/acknowledge transaction on the data-memory bus for
// loads and stores, stalls upstream while the access is outstanding, resolves
// the branch decision and owns the MEM/WB pipeline register.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   Mem_WB            EX/MEM write-back controls ([1]=RegWrite, [0]=MemtoReg)
//   read_En/write_En  load / store request
//   Mem_Br, Zero      branch flag and ALU zero flag
//   DataAddress       ALU result / byte address
//   WriteData         store data
//   dest              destination register
//   mem_rdata/mem_ack data-memory read data and completion strobe
//   mem_req/mem_we/mem_addr/mem_wdata   registered bus request
//   stall             combinational freeze of the upstream pipeline
//   pc_src            combinational branch-taken
//   WB_ctrl/ReadData/ALUResult/WB_dest  MEM/WB register
//   misalign_err      sticky: access to a non word-aligned address
//   bus_err           sticky: bus timeout or simultaneous read/write request
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  Mem_WB,
   input  logic        read_En,
   input  logic        write_En,
   input  logic        Mem_Br,
   input  logic        Zero,
   input  logic [31:0] DataAddress,
   input  logic [31:0] WriteData,
   input  logic [4:0]  dest,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        stall,
   output logic        pc_src,
   output logic [1:0]  WB_ctrl,
   output logic [31:0] ReadData,
   output logic [31:0] ALUResult,
   output logic [4:0]  WB_dest,
   output logic        misalign_err,
   output logic        bus_err
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] wait_q;
   logic [CNT_W-1:0] wait_d;

   logic             mem_req_d;
   logic             mem_we_d;
   logic [31:0]      mem_addr_d;
   logic [31:0]      mem_wdata_d;
   logic [1:0]       wb_ctrl_d;
   logic [31:0]      read_data_d;
   logic [31:0]      alu_result_d;
   logic [4:0]       wb_dest_d;
   logic             misalign_err_d;
   logic             bus_err_d;
   logic             stall_c;

   logic             access;
   logic             aligned;
   logic             last_wait;

   assign access    = read_En ^ write_En;
   assign aligned   = (DataAddress[1:0] == 2'b00);
   assign last_wait = (wait_q == CNT_W'(TIMEOUT - 1));

   // Branch resolution is independent of the memory state machine
   assign pc_src = Mem_Br & Zero;

   // Freeze is masked while reset is held so the pipeline sees a clean 0
   assign stall = stall_c & rst;

   // Next-state and next-register logic; MEM/WB defaults to a bubble
   always_comb begin
      state_d        = state_q;
      wait_d         = wait_q;
      mem_req_d      = mem_req;
      mem_we_d       = mem_we;
      mem_addr_d     = mem_addr;
      mem_wdata_d    = mem_wdata;
      wb_ctrl_d      = 2'b00;
      read_data_d    = 32'd0;
      alu_result_d   = 32'd0;
      wb_dest_d      = 5'd0;
      misalign_err_d = misalign_err;
      bus_err_d      = bus_err;
      stall_c        = 1'b0;

      case (state_q)
         IDLE: begin
            if (read_En & write_En) begin
               bus_err_d = 1'b1;
            end else if (access & !aligned) begin
               misalign_err_d = 1'b1;
            end else if (access) begin
               // Launch the bus cycle; instruction retires when acked
               stall_c     = 1'b1;
               state_d     = ACCESS;
               wait_d      = '0;
               mem_req_d   = 1'b1;
               mem_we_d    = write_En;
               mem_addr_d  = {DataAddress[31:2], 2'b00};
               mem_wdata_d = WriteData;
            end else begin
               wb_ctrl_d    = Mem_WB;
               alu_result_d = DataAddress;
               wb_dest_d    = dest;
            end
         end

         ACCESS: begin
            if (mem_ack) begin
               wb_ctrl_d    = Mem_WB;
               alu_result_d = DataAddress;
               wb_dest_d    = dest;
               read_data_d  = mem_we ? 32'd0 : mem_rdata;
               mem_req_d    = 1'b0;
               state_d      = IDLE;
            end else if (last_wait) begin
               // Abort: upstream is released in this final cycle
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
               state_d   = IDLE;
            end else begin
               stall_c = 1'b1;
               wait_d  = wait_q + CNT_W'(1);
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         wait_q       <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'd0;
         mem_wdata    <= 32'd0;
         WB_ctrl      <= 2'b00;
         ReadData     <= 32'd0;
         ALUResult    <= 32'd0;
         WB_dest      <= 5'd0;
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         mem_req      <= mem_req_d;
         mem_we       <= mem_we_d;
         mem_addr     <= mem_addr_d;
         mem_wdata    <= mem_wdata_d;
         WB_ctrl      <= wb_ctrl_d;
         ReadData     <= read_data_d;
         ALUResult    <= alu_result_d;
         WB_dest      <= wb_dest_d;
         misalign_err <= misalign_err_d;
         bus_err      <= bus_err_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage: reset, a vector table of single-cycle
// operations, directed multi-cycle sequences, and a random instruction stream
// checked against a transaction-level model with a behavioural data memory.
// -----------------------------------------------------------------------------
module tb_mem_stage;

   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  Mem_WB;
   logic        read_En;
   logic        write_En;
   logic        Mem_Br;
   logic        Zero;
   logic [31:0] DataAddress;
   logic [31:0] WriteData;
   logic [4:0]  dest;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        stall;
   logic        pc_src;
   logic [1:0]  WB_ctrl;
   logic [31:0] ReadData;
   logic [31:0] ALUResult;
   logic [4:0]  WB_dest;
   logic        misalign_err;
   logic        bus_err;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .Mem_WB       (Mem_WB),
      .read_En      (read_En),
      .write_En     (write_En),
      .Mem_Br       (Mem_Br),
      .Zero         (Zero),
      .DataAddress  (DataAddress),
      .WriteData    (WriteData),
      .dest         (dest),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .stall        (stall),
      .pc_src       (pc_src),
      .WB_ctrl      (WB_ctrl),
      .ReadData     (ReadData),
      .ALUResult    (ALUResult),
      .WB_dest      (WB_dest),
      .misalign_err (misalign_err),
      .bus_err      (bus_err)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Expected sticky error flags
   logic exp_mis;
   logic exp_be;

   // Behavioural data memory
   logic [31:0] mem_model [logic [31:0]];

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'hA5C3_0F96;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] wb, input logic rd, input logic wr,
                        input logic br, input logic z, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] dst);
      Mem_WB = wb; read_En = rd; write_En = wr; Mem_Br = br; Zero = z;
      DataAddress = addr; WriteData = wd; dest = dst;
   endtask

   task automatic idle_inputs();
      drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      mem_ack = 1'b0; mem_rdata = 32'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      exp_mis = 1'b0;
      exp_be  = 1'b0;
   endtask

   task automatic chk_errs();
      chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
      chk("bus_err", 32'(bus_err), 32'(exp_be));
   endtask

   // One aligned load/store; memory acks on the k-th cycle mem_req is seen high
   task automatic mem_op(input logic is_wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] wb, input logic [4:0] dst, input int k,
                         input logic [31:0] rdata);
      int stalls = 0;
      int reqs   = 0;
      bit done   = 0;
      Mem_WB = wb; read_En = !is_wr; write_En = is_wr;
      DataAddress = addr; WriteData = wd; dest = dst;
      mem_ack = 1'b0; mem_rdata = 32'h1111_1111;
      chk("req_gap", 32'(mem_req), 32'd0);
      for (int c = 0; c < int'(TIMEOUT) + 4 && !done; c++) begin
         if (mem_req) begin
            reqs++;
            chk("bus_we", 32'(mem_we), 32'(is_wr));
            chk("bus_addr", mem_addr, addr);
            if (is_wr) chk("bus_wdata", mem_wdata, wd);
            if (reqs == k) begin
               mem_ack   = 1'b1;
               mem_rdata = rdata;
            end
         end
         #1;
         chk("pc_src_acc", 32'(pc_src), 32'(Mem_Br & Zero));
         if (stall) stalls++;
         done = mem_ack;
         tick();
         if (!done) chk("stall_bubble", 32'(WB_ctrl), 32'd0);
         mem_ack   = 1'b0;
         mem_rdata = 32'h2222_2222;
      end
      chk("ack_reached", 32'(done), 32'd1);
      chk("stall_cycles", 32'(stalls), 32'(k));
      chk("req_after_ack", 32'(mem_req), 32'd0);
      chk("wb_ctrl_acc", 32'(WB_ctrl), 32'(wb));
      chk("alu_result_acc", ALUResult, addr);
      chk("wb_dest_acc", 32'(WB_dest), 32'(dst));
      chk("read_data_acc", ReadData, is_wr ? 32'd0 : rdata);
   endtask

   typedef struct {
      logic [1:0]  wb;
      logic        rd;
      logic        wr;
      logic        br;
      logic        z;
      logic [31:0] addr;
      logic [4:0]  dst;
      logic        e_stall;
      logic        e_pc;
      logic [1:0]  e_wb;
      logic        chk_data;
      logic [31:0] e_alu;
      logic [4:0]  e_dst;
      logic        e_mis;
      logic        e_be;
   } vec_t;

   vec_t vt [8];

   initial begin
      int reqs, stalls;
      bit seen, back;

      vt[0] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 5'd5,  1'b0, 1'b0, 2'b10, 1'b1, 32'h0000_1234, 5'd5,  1'b0, 1'b0};
      vt[1] = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 5'd0,  1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0040, 5'd0,  1'b0, 1'b0};
      vt[2] = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 5'd31, 1'b0, 1'b0, 2'b11, 1'b1, 32'hFFFF_FFFC, 5'd31, 1'b0, 1'b0};
      vt[3] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 5'd7,  1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0003, 5'd7,  1'b0, 1'b0};
      vt[4] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0102, 5'd9,  1'b0, 1'b0, 2'b00, 1'b0, 32'd0,         5'd0,  1'b1, 1'b0};
      vt[5] = '{2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0201, 5'd0,  1'b0, 1'b1, 2'b00, 1'b0, 32'd0,         5'd0,  1'b1, 1'b0};
      vt[6] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 5'd2,  1'b0, 1'b0, 2'b00, 1'b0, 32'd0,         5'd0,  1'b1, 1'b1};
      vt[7] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_ABCD, 5'd3,  1'b0, 1'b0, 2'b10, 1'b1, 32'h0000_ABCD, 5'd3,  1'b1, 1'b1};

      // Reset held with a pending load and a stray ack
      idle_inputs();
      rst = 1'b0;
      read_En = 1'b1; DataAddress = 32'h100; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_stall", 32'(stall), 32'd0);
         chk("rst_mem_req", 32'(mem_req), 32'd0);
         chk("rst_mem_we", 32'(mem_we), 32'd0);
         chk("rst_mem_addr", mem_addr, 32'd0);
         chk("rst_mem_wdata", mem_wdata, 32'd0);
         chk("rst_wb_ctrl", 32'(WB_ctrl), 32'd0);
         chk("rst_read_data", ReadData, 32'd0);
         chk("rst_alu_result", ALUResult, 32'd0);
         chk("rst_wb_dest", 32'(WB_dest), 32'd0);
         chk("rst_misalign", 32'(misalign_err), 32'd0);
         chk("rst_bus_err", 32'(bus_err), 32'd0);
      end
      idle_inputs();
      rst = 1'b1;
      exp_mis = 1'b0; exp_be = 1'b0;

      // Single-cycle table, stray ack present throughout
      for (int i = 0; i < 8; i++) begin
         drive(vt[i].wb, vt[i].rd, vt[i].wr, vt[i].br, vt[i].z, vt[i].addr, 32'h5555_AAAA, vt[i].dst);
         mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
         #1;
         chk("tbl_stall", 32'(stall), 32'(vt[i].e_stall));
         chk("tbl_pc_src", 32'(pc_src), 32'(vt[i].e_pc));
         tick();
         chk("tbl_mem_req", 32'(mem_req), 32'd0);
         chk("tbl_wb_ctrl", 32'(WB_ctrl), 32'(vt[i].e_wb));
         if (vt[i].chk_data) begin
            chk("tbl_alu_result", ALUResult, vt[i].e_alu);
            chk("tbl_wb_dest", 32'(WB_dest), 32'(vt[i].e_dst));
            chk("tbl_read_data", ReadData, 32'd0);
         end
         chk("tbl_misalign", 32'(misalign_err), 32'(vt[i].e_mis));
         chk("tbl_bus_err", 32'(bus_err), 32'(vt[i].e_be));
      end

      // Load 0x100 acked on the 3rd request cycle, then an immediate-ack store
      do_reset();
      mem_op(1'b0, 32'h100, 32'd0, 2'b11, 5'd4, 3, 32'hDEAD_BEEF);
      mem_op(1'b1, 32'h200, 32'hCAFE_F00D, 2'b00, 5'd0, 1, 32'h7777_7777);

      // Misaligned load refused, later aligned load still completes
      drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h102, 32'd0, 5'd8);
      #1;
      chk("mis_stall", 32'(stall), 32'd0);
      tick();
      chk("mis_req", 32'(mem_req), 32'd0);
      chk("mis_wb_ctrl", 32'(WB_ctrl), 32'd0);
      chk("mis_flag", 32'(misalign_err), 32'd1);
      mem_op(1'b0, 32'h104, 32'd0, 2'b11, 5'd8, 2, 32'h0BAD_F00D);

      // Timeout with no ack
      do_reset();
      drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'd0, 5'd6);
      reqs = 0; stalls = 0; seen = 0; back = 0;
      for (int c = 0; c < 40 && !back; c++) begin
         #1;
         if (stall) stalls++;
         tick();
         if (mem_req) begin
            seen = 1;
            reqs++;
         end else if (seen) begin
            back = 1;
         end
      end
      chk("to_returned", 32'(back), 32'd1);
      chk("to_req_cycles", 32'(reqs), TIMEOUT);
      chk("to_stall_cycles", 32'(stalls), TIMEOUT);
      chk("to_bus_err", 32'(bus_err), 32'd1);
      chk("to_wb_ctrl", 32'(WB_ctrl), 32'd0);
      drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'd0, 5'd1);
      #1;
      chk("to_idle_stall", 32'(stall), 32'd0);
      tick();
      chk("to_idle_req", 32'(mem_req), 32'd0);
      chk("to_idle_wb", 32'(WB_ctrl), 32'b10);
      do_reset();
      chk("to_bus_err_clr", 32'(bus_err), 32'd0);

      // Reset in the middle of an access
      drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'd0, 5'd2);
      tick();
      tick();
      chk("mid_req_up", 32'(mem_req), 32'd1);
      rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      chk("mid_req_drop", 32'(mem_req), 32'd0);
      chk("mid_wb_ctrl", 32'(WB_ctrl), 32'd0);
      chk("mid_read_data", ReadData, 32'd0);
      chk("mid_stall", 32'(stall), 32'd0);
      rst = 1'b1;
      idle_inputs();
      #1;
      chk("mid_post_stall", 32'(stall), 32'd0);
      tick();
      chk("mid_post_req", 32'(mem_req), 32'd0);
      chk("mid_post_wb", 32'(WB_ctrl), 32'd0);

      // Random instruction stream against the transaction model
      do_reset();
      for (int i = 0; i < 150; i++) begin
         int          op;
         logic [31:0] a;
         logic [31:0] wd;
         logic [1:0]  wb;
         logic [4:0]  dst;
         logic        br;
         logic        z;
         op  = int'($urandom_range(0, 9));
         a   = 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
         wd  = $urandom;
         wb  = 2'($urandom);
         dst = 5'($urandom);
         br  = 1'($urandom);
         z   = 1'($urandom);
         if (op <= 2) begin
            drive(wb, 1'b0, 1'b0, br, z, $urandom, wd, dst);
            mem_ack = 1'($urandom); mem_rdata = $urandom;
            #1;
            chk("rnd_alu_stall", 32'(stall), 32'd0);
            chk("rnd_pc_src", 32'(pc_src), 32'(br & z));
            tick();
            chk("rnd_alu_wb", 32'(WB_ctrl), 32'(wb));
            chk("rnd_alu_res", ALUResult, DataAddress);
            chk("rnd_alu_dest", 32'(WB_dest), 32'(dst));
            chk("rnd_alu_rdata", ReadData, 32'd0);
         end else if (op <= 7) begin
            Mem_Br = br; Zero = z;
            if (op <= 5) begin
               mem_op(1'b0, a, wd, wb, dst, int'($urandom_range(1, 4)), model_rd(a));
            end else begin
               mem_op(1'b1, a, wd, wb, dst, int'($urandom_range(1, 4)), $urandom);
               mem_model[a] = wd;
            end
         end else begin
            if (op == 8) begin
               a = a + 32'($urandom_range(1, 3));
               if ($urandom_range(0, 1) == 1) drive(wb, 1'b1, 1'b0, br, z, a, wd, dst);
               else drive(wb, 1'b0, 1'b1, br, z, a, wd, dst);
               exp_mis = 1'b1;
            end else begin
               drive(wb, 1'b1, 1'b1, br, z, a, wd, dst);
               exp_be = 1'b1;
            end
            mem_ack = 1'($urandom);
            #1;
            chk("rnd_err_stall", 32'(stall), 32'd0);
            tick();
            chk("rnd_err_req", 32'(mem_req), 32'd0);
            chk("rnd_err_wb", 32'(WB_ctrl), 32'd0);
         end
         chk_errs();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
